// File: rtl/param_updown_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : param_updown_counter_if
//  Description : Control/status bundle for param_updown_counter.
//                master drives the controls and observes the outputs,
//                slave is the counter itself.
//  Signals     : en, up, load, load_val[WIDTH], sat_mode, cmp_val[WIDTH],
//                clr_ovf (master -> slave)
//                count[WIDTH], tc, ovf, match (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface param_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             sat_mode;
    logic [WIDTH-1:0] cmp_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             match;

    modport master (
        output en, up, load, load_val, sat_mode, cmp_val, clr_ovf,
        input  count, tc, ovf, match
    );

    modport slave (
        input  en, up, load, load_val, sat_mode, cmp_val, clr_ovf,
        output count, tc, ovf, match
    );
endinterface
`default_nettype wire

// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : param_updown_counter
//  Description : WIDTH-bit synchronous up/down counter with parallel load,
//                wrap/saturate boundary mode, combinational compare match,
//                one-cycle terminal-count pulse and sticky overflow flag.
//                Optional prescaler enabled by defining COUNTER_PRESCALE_EN:
//                the counter then steps once per PRESCALE enabled cycles.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - param_updown_counter_if.slave
//                       (en, up, load, load_val, sat_mode, cmp_val, clr_ovf
//                        in; count, tc, ovf, match out)
//  Parameters  : WIDTH (2..16), RESET_VAL, PRESCALE (>=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module param_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0,
    parameter int PRESCALE  = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    param_updown_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] c_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_RESET = WIDTH'(RESET_VAL);

    // Elaboration-time guard on the parameter ranges.
    if (WIDTH < 2 || WIDTH > 16 || PRESCALE < 1 ||
        RESET_VAL < 0 || RESET_VAL > (2 ** WIDTH) - 1) begin : g_param_check
        $error("param_updown_counter: parameter out of range");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_tick;
    logic             w_step;
    logic             w_boundary;

    // ------------------------------------------------------------------
    // Step qualifier. With the prescaler, tick is high on the enabled
    // cycle that completes a PRESCALE-long period.
    // ------------------------------------------------------------------
`ifdef COUNTER_PRESCALE_EN
    // A 1-bit register is kept for PRESCALE=1; it then never leaves 0,
    // so tick is permanently high.
    localparam int               c_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);

    logic [c_PS_W-1:0] r_ps;

    assign w_tick = (r_ps == c_PS_LAST);

    always_ff @(posedge clk) begin
        if (rst || bus.load) begin
            r_ps <= '0;
        end else if (bus.en) begin
            r_ps <= w_tick ? '0 : r_ps + 1'b1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    assign w_step     = bus.en & w_tick & ~bus.load;
    assign w_boundary = bus.up ? (r_count == c_MAX) : (r_count == '0);

    // ------------------------------------------------------------------
    // Counter, terminal count and sticky overflow.
    // tc defaults low every edge so it is a single-cycle pulse that lines
    // up with the count produced by the boundary step.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_RESET;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_tc <= 1'b0;

            // Clear first so a boundary step on the same edge overrides it.
            if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end

            if (bus.load) begin
                r_count <= bus.load_val;
            end else if (w_step) begin
                if (w_boundary) begin
                    r_tc  <= 1'b1;
                    r_ovf <= 1'b1;
                    if (!bus.sat_mode) begin
                        r_count <= bus.up ? '0 : c_MAX;
                    end
                end else begin
                    r_count <= bus.up ? r_count + 1'b1 : r_count - 1'b1;
                end
            end
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.ovf   = r_ovf;
    assign bus.match = (r_count == bus.cmp_val);

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_updown_counter
//  Description : Scoreboard bench for param_updown_counter. Each driven
//                cycle pushes the reference model's expected outputs into a
//                queue; an independent monitor pops one entry per clock and
//                compares count, tc, ovf and match.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

    localparam int W    = 8;
    localparam int RV   = 0;
    localparam int PS   = 4;
    localparam int MAXV = (1 << W) - 1;

    typedef struct {
        int unsigned id;
        int          count;
        bit          tc;
        bit          ovf;
        bit          match;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    param_updown_counter_if #(.WIDTH(W)) bus ();

    param_updown_counter #(
        .WIDTH     (W),
        .RESET_VAL (RV),
        .PRESCALE  (PS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned n_issued = 0;

    // Reference model state, plain integers.
    int m_count = RV;
    bit m_ovf   = 1'b0;
    int m_en_cycles = 0;

    // ------------------------------------------------------------------
    // Monitor: one expected entry per clock edge.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (int'(bus.count) != e.count) begin
                    n_fail++;
                    $display("FAIL count cyc=%0d got=%02h exp=%02h", e.id, bus.count, e.count);
                end
                n_checks++;
                if (bus.tc !== e.tc) begin
                    n_fail++;
                    $display("FAIL tc cyc=%0d got=%0b exp=%0b", e.id, bus.tc, e.tc);
                end
                n_checks++;
                if (bus.ovf !== e.ovf) begin
                    n_fail++;
                    $display("FAIL ovf cyc=%0d got=%0b exp=%0b", e.id, bus.ovf, e.ovf);
                end
                n_checks++;
                if (bus.match !== e.match) begin
                    n_fail++;
                    $display("FAIL match cyc=%0d got=%0b exp=%0b", e.id, bus.match, e.match);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: one call per clock edge, written from the rules
    // (priority rst > load > step > hold, integer arithmetic for range).
    // ------------------------------------------------------------------
    task automatic model_edge(input bit r, input bit e, input bit u, input bit l,
                              input int lv, input bit s, input int cmp, input bit c);
        int   nxt;
        bit   tc;
        bit   tick;
        exp_t x;
        tc   = 1'b0;
        tick = 1'b1;
        if (r) begin
            m_count     = RV;
            m_ovf       = 1'b0;
            m_en_cycles = 0;
        end else begin
            if (c) m_ovf = 1'b0;
            if (l) begin
                m_count     = lv;
                m_en_cycles = 0;
            end else if (e) begin
`ifdef COUNTER_PRESCALE_EN
                m_en_cycles = m_en_cycles + 1;
                tick = (m_en_cycles == PS);
                if (tick) m_en_cycles = 0;
`endif
                if (tick) begin
                    nxt = u ? m_count + 1 : m_count - 1;
                    if (nxt > MAXV || nxt < 0) begin
                        tc    = 1'b1;
                        m_ovf = 1'b1;
                        if (!s) m_count = (nxt + MAXV + 1) % (MAXV + 1);
                    end else begin
                        m_count = nxt;
                    end
                end
            end
        end
        x.id    = n_issued;
        x.count = m_count;
        x.tc    = tc;
        x.ovf   = m_ovf;
        x.match = (m_count == cmp);
        sb.push_back(x);
        n_issued++;
    endtask

    // Drive one cycle of inputs at the falling edge and record expectation.
    task automatic drive(input bit r, input bit e, input bit u, input bit l,
                         input logic [W-1:0] lv, input bit s,
                         input logic [W-1:0] cmp, input bit c);
        @(negedge clk);
        rst          = r;
        bus.en       = e;
        bus.up       = u;
        bus.load     = l;
        bus.load_val = lv;
        bus.sat_mode = s;
        bus.cmp_val  = cmp;
        bus.clr_ovf  = c;
        model_edge(r, e, u, l, int'(lv), s, int'(cmp), c);
    endtask

    function automatic logic [W-1:0] pick_val();
        int k;
        k = $urandom_range(0, 5);
        case (k)
            0:       pick_val = '0;
            1:       pick_val = W'(1);
            2:       pick_val = W'(MAXV - 1);
            3:       pick_val = W'(MAXV);
            default: pick_val = W'($urandom_range(0, MAXV));
        endcase
    endfunction

    initial begin
        logic [W-1:0] cmp;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.up       = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.sat_mode = 1'b0;
        bus.cmp_val  = '0;
        bus.clr_ovf  = 1'b0;

        // Reset then hold.
        drive(1, 0, 0, 0, 8'h00, 0, 8'hAA, 0);
        repeat (5) drive(0, 0, 0, 0, 8'h00, 0, 8'hAA, 0);

        // Up-count wrap, then clear overflow.
        drive(0, 0, 1, 1, 8'hFD, 0, 8'hAA, 0);
        repeat (4) drive(0, 1, 1, 0, 8'h00, 0, 8'hAA, 0);
        drive(0, 0, 1, 0, 8'h00, 0, 8'hAA, 1);
        drive(0, 0, 1, 0, 8'h00, 0, 8'hAA, 0);

        // Down-count saturate.
        drive(0, 0, 0, 1, 8'h02, 1, 8'hAA, 0);
        repeat (4) drive(0, 1, 0, 0, 8'h00, 1, 8'hAA, 0);

        // Load beats step at the top of range; rst beats load.
        drive(0, 0, 1, 1, 8'hFF, 0, 8'h55, 0);
        drive(0, 1, 1, 1, 8'h55, 0, 8'h55, 0);
        drive(1, 1, 1, 1, 8'h77, 0, 8'h00, 0);
        // Overflow step with clear on the same edge: set wins.
        drive(0, 0, 1, 1, 8'hFF, 0, 8'hAA, 0);
        repeat (PS) drive(0, 1, 1, 0, 8'h00, 0, 8'hAA, 1);

        // Compare window around 0x10.
        drive(0, 0, 1, 1, 8'h0E, 0, 8'h10, 0);
        repeat (4 * PS) drive(0, 1, 1, 0, 8'h00, 0, 8'h10, 0);

`ifdef COUNTER_PRESCALE_EN
        // Prescaled stepping, with an enable gap mid-period.
        drive(1, 0, 1, 0, 8'h00, 0, 8'h03, 0);
        repeat (12) drive(0, 1, 1, 0, 8'h00, 0, 8'h03, 0);
        repeat (2)  drive(0, 1, 1, 0, 8'h00, 0, 8'h03, 0);
        repeat (2)  drive(0, 0, 1, 0, 8'h00, 0, 8'h03, 0);
        repeat (4)  drive(0, 1, 1, 0, 8'h00, 0, 8'h03, 0);
`endif

        // Randomized traffic biased toward boundaries and matches.
        for (int i = 0; i < 400; i++) begin
            cmp = ($urandom_range(0, 1) == 0) ? W'(m_count) : pick_val();
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0),
                  pick_val(),
                  $urandom_range(0, 1) == 1,
                  cmp,
                  ($urandom_range(0, 9) == 0));
        end

        // Drain the scoreboard with a bounded wait.
        @(negedge clk);
        bus.en   = 1'b0;
        bus.load = 1'b0;
        for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the 8-bit demo datapath: a WIDTH-bit synchronous up/down counter with parallel load, wrap or saturate mode, compare-match output, terminal-count pulse and sticky overflow flag.
- Sits behind the tt_um_* top wrapper. The wrapper maps ui_in/uio_in onto the control and load inputs and count onto uo_out.
- Single clock domain.

Parameters:
- WIDTH, 8, counter/load/compare width in bits (2..16).
- RESET_VAL, 0, value count takes on reset (must fit WIDTH).
- PRESCALE, 4, enabled cycles per count step when COUNTER_PRESCALE_EN is defined (>=1); ignored otherwise.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value loaded when load=1
- sat_mode  in  1  boundary mode: 1 = saturate, 0 = wrap
- cmp_val  in  WIDTH  compare value
- clr_ovf  in  1  clears sticky overflow flag
- count  out  WIDTH  registered counter value
- tc  out  1  registered terminal-count pulse
- ovf  out  1  registered sticky overflow/underflow flag
- match  out  1  combinational, count == cmp_val

Behaviour:
- Reset (rst=1 at clk edge):
  - count=RESET_VAL, tc=0, ovf=0, prescaler=0.
  - Overrides every other input.
- Priority per edge: rst > load > step > hold.
- Load: count<=load_val next cycle, independent of en. tc=0 that cycle. Prescaler is cleared. ovf is unchanged.
- Step condition: en=1 and tick=1 and load=0. tick is defined under Optional Feature.
- Step, non-boundary:
  - count <= count+1 when up=1.
  - count <= count-1 when up=0.
  - tc=0.
- Boundary cases (up=1 and count=2^WIDTH-1, or up=0 and count=0):
  - Wrap mode: count wraps to 0 (up) or 2^WIDTH-1 (down).
  - Saturate mode: count holds.
  - Both modes: tc=1 for exactly that one cycle, aligned with the updated count, and ovf<=1.
- tc is 0 in every cycle that was not a boundary step. Repeated boundary steps in saturate mode give tc=1 on each step.
- ovf is sticky. clr_ovf=1 clears it on the next edge. If set and clear happen on the same edge, the set wins (ovf=1).
- en=0 with load=0: count, tc=0 and prescaler all hold.
- sat_mode and up are sampled on every edge. Changing either mid-count takes effect on the next step with no glitch.
- match: purely combinational compare, valid the same cycle count changes. No latency through the register.
- Latency: count reflects a load or step 1 cycle after the sampling edge.
- Arithmetic is modulo 2^WIDTH. No carry-out port besides tc and ovf.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler of ceil(log2(PRESCALE)) bits increments on each edge with en=1 and load=0.
  - tick=1 when prescaler==PRESCALE-1, and the prescaler then returns to 0. So count steps once per PRESCALE enabled cycles.
  - PRESCALE=1 behaves as undefined.
  - The prescaler holds when en=0 and clears on rst or load.
- Not defined: tick is tied to 1, so count steps on every enabled cycle. No prescaler flops are synthesised and the PRESCALE parameter has no effect.

Test Plan (WIDTH=8, RESET_VAL=0, macro undefined unless stated):
1. Reset and hold: rst=1 one cycle, then en=0 for 5 cycles -> count=0x00, tc=0, ovf=0 throughout.
2. Up-count wrap: load 0xFD, then en=1, up=1, sat_mode=0 for 4 cycles -> count 0xFE, 0xFF, 0x00 (tc=1, ovf=1), 0x01 (tc=0). Then clr_ovf=1 -> ovf=0 next cycle.
3. Down-count saturate: load 0x02, en=1, up=0, sat_mode=1 for 4 cycles -> count 0x01, 0x00, 0x00 (tc=1), 0x00 (tc=1). ovf=1 stays set.
4. Priority and collision:
   - load=1 (0x55) together with en=1, up=1 at count=0xFF -> count=0x55, tc=0.
   - rst=1 together with load=1 -> count=0x00.
   - Overflow step with clr_ovf=1 on the same edge -> ovf=1.
5. Compare: cmp_val=0x10, load 0x0E, count up -> match=0 at 0x0E and 0x0F, match=1 while count=0x10 (same cycle), match=0 at 0x11.
6. With COUNTER_PRESCALE_EN and PRESCALE=4: en=1, up=1 from 0 for 12 cycles -> count reaches 0x03, stepping every 4th cycle. Dropping en for 2 cycles mid-period delays the next step by 2 cycles.
